// File: rtl/reg_scoreboard_deco_if.sv
// Bundle for the register-file write-path scoreboard: issue handshake,
// writeback decode, two read-port hazard probes and the scoreboard view.
interface reg_scoreboard_deco_if #(
  parameter int ADDR_W = 5
);
  localparam int NREG = 2 ** ADDR_W;

  // Issue handshake: issue_en is the valid, !issue_stall is the ready; an
  // issue transfers on a cycle where both hold, otherwise upstream keeps
  // issue_addr stable and retries.
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_stall;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [NREG-1:0]   wr_onehot;

  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              hazard_a;
  logic              hazard_b;

  logic [NREG-1:0]   busy;
  logic              err_spurious;

  modport master (
    output issue_en, issue_addr, wb_en, wb_addr, rd_addr_a, rd_addr_b,
    input  issue_stall, wr_onehot, hazard_a, hazard_b, busy, err_spurious
  );

  modport slave (
    input  issue_en, issue_addr, wb_en, wb_addr, rd_addr_a, rd_addr_b,
    output issue_stall, wr_onehot, hazard_a, hazard_b, busy, err_spurious
  );
endinterface

// File: rtl/reg_scoreboard_deco.sv
// Writeback address decoder with a pending-write scoreboard and RAW/WAW hazard
// flags. Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle writeback mask hazards/stall.
module reg_scoreboard_deco #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input logic                  clk,
  input logic                  reset,
  reg_scoreboard_deco_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] onehot_q, onehot_d;
  logic            err_q, err_d;

  logic raw_a, raw_b, waw;
  logic wb_live, issue_take;

  assign wb_live = bus.wb_en && (bus.wb_addr != ZERO_IDX);

  // XZR is never tracked, so it can never raise a hazard or a stall.
  assign raw_a = busy_q[bus.rd_addr_a] && (bus.rd_addr_a != ZERO_IDX);
  assign raw_b = busy_q[bus.rd_addr_b] && (bus.rd_addr_b != ZERO_IDX);
  assign waw   = bus.issue_en && busy_q[bus.issue_addr] && (bus.issue_addr != ZERO_IDX);

`ifdef SCOREBOARD_BYPASS_EN
  logic wb_hit_a, wb_hit_b, wb_hit_issue;

  // The register file forwards the data being written this cycle.
  assign wb_hit_a     = bus.wb_en && (bus.wb_addr == bus.rd_addr_a);
  assign wb_hit_b     = bus.wb_en && (bus.wb_addr == bus.rd_addr_b);
  assign wb_hit_issue = bus.wb_en && (bus.wb_addr == bus.issue_addr);

  assign bus.hazard_a    = raw_a && !wb_hit_a;
  assign bus.hazard_b    = raw_b && !wb_hit_b;
  assign bus.issue_stall = waw && !wb_hit_issue;
`else
  assign bus.hazard_a    = raw_a;
  assign bus.hazard_b    = raw_b;
  assign bus.issue_stall = waw;
`endif

  assign issue_take = bus.issue_en && !bus.issue_stall && (bus.issue_addr != ZERO_IDX);

  always_comb begin
    onehot_d = '0;
    busy_d   = busy_q;
    err_d    = err_q;
    if (wb_live) begin
      onehot_d[bus.wb_addr] = 1'b1;
      if (!busy_q[bus.wb_addr]) err_d = 1'b1;
    end
    if (bus.wb_en) busy_d[bus.wb_addr] = 1'b0;
    // Set after clear: a new producer outranks a retiring one on the same register.
    if (issue_take) busy_d[bus.issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      onehot_q <= '0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      onehot_q <= onehot_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.wr_onehot    = onehot_q;
  assign bus.err_spurious = err_q;
endmodule

// File: tb/tb_reg_scoreboard_deco.sv
// Scoreboard bench for reg_scoreboard_deco: a driver pushes expected outputs from
// a register-level model, a negedge monitor pops and compares.
module tb_reg_scoreboard_deco;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam int Z      = 31;
  localparam int W      = 2 * NREG + 4;
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  reg_scoreboard_deco_if #(.ADDR_W(ADDR_W)) bus ();

  reg_scoreboard_deco #(.ADDR_W(ADDR_W), .ZERO_REG(Z)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: one flag per architectural register plus the two outputs
  bit              m_busy [NREG];
  logic [NREG-1:0] m_onehot;
  bit              m_err;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] busy_vec();
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_onehot = '0;
    m_err    = 1'b0;
  endtask

  // driver: apply one cycle of inputs, push what the outputs must show, advance the model
  task automatic drive(input bit ie, input int ia, input bit we, input int wa,
                       input int ra, input int rb);
    bit stall, ha, hb;
    @(posedge clk);
    #1;
    bus.issue_en   = ie;
    bus.issue_addr = 5'(ia);
    bus.wb_en      = we;
    bus.wb_addr    = 5'(wa);
    bus.rd_addr_a  = 5'(ra);
    bus.rd_addr_b  = 5'(rb);
    stall = ie && m_busy[ia] && (ia != Z) && !(BYP && we && (wa == ia));
    ha    = m_busy[ra] && (ra != Z) && !(BYP && we && (wa == ra));
    hb    = m_busy[rb] && (rb != Z) && !(BYP && we && (wa == rb));
    exp_q.push_back({busy_vec(), m_onehot, m_err, stall, ha, hb});
    if (we && (wa != Z) && !m_busy[wa]) m_err = 1'b1;
    m_onehot = (we && (wa != Z)) ? (32'(1) << wa) : '0;
    if (we) m_busy[wa] = 1'b0;
    if (ie && !stall && (ia != Z)) m_busy[ia] = 1'b1;
  endtask

  task automatic idle(input int ra, input int rb);
    drive(1'b0, 0, 1'b0, 0, ra, rb);
  endtask

  function automatic int rnd_addr();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return Z;
    if (sel < 3) return $urandom_range(0, NREG - 1);
    return $urandom_range(0, 7);
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy",         bus.busy,         e[W-1 -: NREG]);
      chk("wr_onehot",    bus.wr_onehot,    e[NREG+3 -: NREG]);
      chk("err_spurious", bus.err_spurious, e[3]);
      chk("issue_stall",  bus.issue_stall,  e[2]);
      chk("hazard_a",     bus.hazard_a,     e[1]);
      chk("hazard_b",     bus.hazard_b,     e[0]);
      chk("onehot_at_most_one", 64'($countones(bus.wr_onehot) <= 1), 64'(1));
    end
  end

  initial begin
    reset          = 1'b1;
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;
    bus.wb_en      = 1'b0;
    bus.wb_addr    = '0;
    bus.rd_addr_a  = '0;
    bus.rd_addr_b  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",   bus.busy,         0);
    chk("reset_onehot", bus.wr_onehot,    0);
    chk("reset_err",    bus.err_spurious, 0);
    @(negedge clk);
    reset = 1'b0;

    // decode sweep with every trackable register pending
    for (int k = 0; k < Z; k++) drive(1'b1, k, 1'b0, 0, 0, 0);
    for (int k = 0; k < NREG; k++) drive(1'b0, 0, 1'b1, k, k, (k + 1) % NREG);
    idle(0, 0);
    #1 chk("sweep_k31_onehot", bus.wr_onehot, 0);

    // RAW on register 5
    drive(1'b1, 5, 1'b0, 0, 0, 0);
    idle(5, 0);
    #1 chk("raw_pending", bus.hazard_a, 1);
    drive(1'b0, 0, 1'b1, 5, 5, 0);
    #1 chk("raw_wb_cycle", bus.hazard_a, BYP ? 0 : 1);
    idle(5, 0);
    #1 chk("raw_after_wb", bus.hazard_a, 0);

    // WAW on register 7
    drive(1'b1, 7, 1'b0, 0, 0, 0);
    drive(1'b1, 7, 1'b0, 0, 7, 0);
    #1 chk("waw_stall", bus.issue_stall, 1);
    drive(1'b1, 7, 1'b1, 7, 0, 0);
    #1 chk("waw_stall_with_wb", bus.issue_stall, BYP ? 0 : 1);
    idle(0, 0);
    #1 chk("waw_busy7_after", bus.busy[7], BYP ? 1 : 0);
    if (!BYP) drive(1'b1, 7, 1'b0, 0, 0, 0);
    drive(1'b0, 0, 1'b1, 7, 0, 0);

    // simultaneous set/clear on idle register 9
    drive(1'b1, 9, 1'b1, 9, 0, 0);
    idle(0, 0);
    #1 chk("setclr_busy9", bus.busy[9], 1);
    chk("setclr_err", bus.err_spurious, 1);
    drive(1'b0, 0, 1'b1, 9, 0, 0);

    // zero register
    drive(1'b1, Z, 1'b0, 0, 0, Z);
    #1 chk("xzr_stall", bus.issue_stall, 0);
    chk("xzr_hazard_b", bus.hazard_b, 0);
    drive(1'b1, Z, 1'b0, 0, 0, Z);
    #1 chk("xzr_busy", bus.busy[Z], 0);

    // randomized traffic
    for (int n = 0; n < 600; n++)
      drive(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(),
            rnd_addr(), rnd_addr());

    // asynchronous reset mid-run with busy = 0x108
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    drive(1'b1, 3, 1'b0, 0, 0, 0);
    drive(1'b1, 8, 1'b1, 20, 0, 0);
    idle(3, 0);
    @(negedge clk);
    #1;
    chk("pre_reset_busy", bus.busy, 64'h108);
    #1 reset = 1'b1;
    #1;
    chk("midrun_reset_busy",   bus.busy,         0);
    chk("midrun_reset_onehot", bus.wr_onehot,    0);
    chk("midrun_reset_err",    bus.err_spurious, 0);
    chk("midrun_reset_haz_a",  bus.hazard_a,     0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 4, 1'b0, 0, 4, 3);
    idle(4, 3);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard_deco.md
Name: reg_scoreboard_deco

Overview:
- Parametrised successor to the fixed 3-to-8 gate decoder, for the LEGv8 register file write path.
- Decodes an N-bit writeback address into a registered 2^N one-hot write-enable vector.
- Keeps a per-register pending-write scoreboard (busy bits) and flags RAW hazards on two read ports and WAW hazards on issue.
- Sits between decode/issue and the register file; its hazard outputs drive the pipeline stall logic.

Parameters:
ADDR_W, 5, address width; NREG = 2**ADDR_W registers.
ZERO_REG, 31, index of the hardwired zero register (XZR); never busy, never write-enabled, never hazards.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
issue_en  input  1  an instruction with a destination register is issuing this cycle.
issue_addr  input  ADDR_W  destination register of the issuing instruction.
issue_stall  output  1  combinational; issue is refused this cycle (WAW hazard).
wb_en  input  1  writeback valid this cycle.
wb_addr  input  ADDR_W  writeback destination register.
wr_onehot  output  NREG  registered one-hot register-file write enable.
rd_addr_a  input  ADDR_W  read port A register.
rd_addr_b  input  ADDR_W  read port B register.
hazard_a  output  1  combinational; port A reads a pending register.
hazard_b  output  1  combinational; port B reads a pending register.
busy  output  NREG  registered scoreboard vector.
err_spurious  output  1  sticky flag: a writeback arrived for a non-busy register.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation): busy = 0, wr_onehot = 0, err_spurious = 0. Hazards and issue_stall then read 0.
- wr_onehot latency is 1 cycle. On the edge after wb_en = 1 with wb_addr = k != ZERO_REG, bit k is 1 and all other bits are 0. Otherwise the whole vector is 0. At most one bit is ever set.
- Issue handshake:
  - issue_stall = issue_en & busy[issue_addr] & (issue_addr != ZERO_REG).
  - An issue is accepted when issue_en = 1 and issue_stall = 0.
  - An accepted issue to k != ZERO_REG sets busy[k] on the next edge.
  - A refused issue changes no state. Upstream holds issue_addr and retries.
  - Issue to ZERO_REG is always accepted and leaves busy unchanged.
- Writeback: wb_en with wb_addr = k clears busy[k] on the next edge.
- Simultaneous accepted issue and writeback to the same k: set wins, so busy[k] = 1 (the new producer).
- Simultaneous issue and writeback to different registers: both take effect.
- issue_stall reads the pre-edge busy. A same-cycle writeback does not unblock the issue unless SCOREBOARD_BYPASS_EN is defined.
- Spurious writeback: wb_en to k != ZERO_REG with busy[k] = 0 sets err_spurious on the next edge. wr_onehot still pulses, busy[k] stays 0, err_spurious holds until reset.
- hazard_x = busy[rd_addr_x] & (rd_addr_x != ZERO_REG), for x = a, b.
- All indices are unsigned. Full-range addresses (0 to NREG-1) are legal.

Optional Feature:
- Macro: SCOREBOARD_BYPASS_EN.
- Defined:
  - hazard_x is additionally masked when wb_en = 1 and wb_addr = rd_addr_x in the same cycle; the register file forwards the write data.
  - issue_stall is masked when wb_en = 1 and wb_addr = issue_addr; the issue is accepted and busy stays 1 (set wins).
- Not defined: hazards and issue_stall depend on registered busy only. A writeback unblocks dependents one cycle later.

Test Plan:
- Reset check: assert reset mid-run with busy = 0x0000_0108 -> busy, wr_onehot and err_spurious read 0 immediately; hazard_a reads 0 with rd_addr_a = 3.
- Decode sweep: wb_en = 1 with busy preloaded, wb_addr = 0..31 one per cycle -> wr_onehot = 1<<k one cycle later; for k = 31 it reads 0; no two bits ever set.
- RAW hazard: issue_addr = 5 accepted, then rd_addr_a = 5 -> hazard_a = 1 until wb_en with wb_addr = 5; hazard_a = 0 the cycle after the edge (macro off), or in the wb cycle itself (macro on).
- WAW stall: busy[7] = 1, issue_en with issue_addr = 7 -> issue_stall = 1 and busy unchanged; same cycle plus wb_addr = 7 -> stall 1 (macro off) or 0 with busy[7] still 1 (macro on).
- Simultaneous set/clear: issue_addr = 9 (not busy) and wb_addr = 9 in the same cycle -> busy[9] = 1, err_spurious = 1.
- Zero register: issue_addr = 31 and rd_addr_b = 31 -> issue_stall = 0, hazard_b = 0, busy[31] = 0 throughout.
